opl3_i2s_tx: RTL and testbench
==============================

Name: opl3_i2s_tx

Overview:
- Downstream audio stage for the OPL3 synth core.
- Captures the four signed channel outputs once per OPL3 sample period and mixes them to stereo with saturation.
- Buffers the stereo frames in a small FIFO and serialises them as a standard Philips I2S stream for the board codec.
- Runs on clk_i; the OPL3 sample_clk is treated as asynchronous.

Parameters:
- CLK_DIV, 8: clk_i cycles per BCLK half-period, legal range 2..255. BCLK = clk_i/(2*CLK_DIV).
- FIFO_DEPTH, 4: stereo frames buffered. Power of 2, range 2..16.

Ports:
- clk_i  in  1  system clock
- rst_i  in  1  reset; asynchronous, active-high
- enable_i  in  1  1 = run serializer; 0 = idle and flush
- clr_flags_i  in  1  single-cycle pulse; clears the sticky flags
- channel_a_i  in  16  signed OPL3 channel A (left)
- channel_b_i  in  16  signed OPL3 channel B (right)
- channel_c_i  in  16  signed OPL3 channel C (left)
- channel_d_i  in  16  signed OPL3 channel D (right)
- sample_clk_i  in  1  OPL3 sample strobe, asynchronous to clk_i
- i2s_bclk_o  out  1  bit clock
- i2s_lrclk_o  out  1  word select; 0 = left
- i2s_data_o  out  1  serial data, MSB first
- level_o  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy
- overflow_o  out  1  sticky: frame dropped because FIFO was full
- underrun_o  out  1  sticky: frame played while FIFO was empty

Behaviour:
- Reset values: all outputs 0; FIFO empty; sync flops 0; state IDLE; bit counter 0; divider 0; shift register 0.
- Capture:
  - sample_clk_i passes through a 2-flop synchroniser plus an edge flop.
  - A rising edge of the synchronised signal produces one capture pulse, 3 clk_i cycles after the pin edge.
  - channel_*_i are stable for a full sample period after sample_clk rises and are sampled directly on the capture pulse.
- Mix:
  - L = sat16(A + C), R = sat16(B + D), using 17-bit signed sums.
  - Saturation limits: above 32767 gives 0x7FFF; below -32768 gives 0x8000.
- Push:
  - Mixed frame {L,R} is written to the FIFO in the cycle after the capture pulse (one registered mix stage).
  - If the FIFO is full: the frame is dropped, contents are unchanged, overflow_o is set.
  - Pushes occur only when enable_i = 1.
- FIFO:
  - Synchronous, FIFO_DEPTH x 32 bits, read and write pointers wrap at FIFO_DEPTH.
  - Push and pop in the same cycle are both honoured, level unchanged. If the FIFO is full, a simultaneous push is still accepted because the pop frees an entry.
- States:
  - IDLE: bclk, lrclk and data held at 0; divider and bit counter at 0; FIFO flushed. Goes to RUN when enable_i = 1.
  - RUN: free-running divider. Goes to IDLE immediately when enable_i = 0, including mid-frame; the partial frame is discarded.
- BCLK:
  - Divider counts 0..CLK_DIV-1; BCLK toggles at terminal count.
  - The first toggle after entering RUN is a rising edge.
  - Data and lrclk change only on BCLK falling edges.
- Bit counter p:
  - Counts 0..31, advances on each falling edge, wraps 31 -> 0.
  - A period is the BCLK cycle that starts at a falling edge.
- Frame load:
  - At the falling edge entering p = 1, the shift register loads W = {L,R} from the FIFO head and pops.
  - If the FIFO is empty: W = 0 and underrun_o is set.
- Data timing:
  - data_o during period p (p = 1..31) = W[32-p].
  - During the following p = 0, data_o = W[0] (R LSB, one-bit I2S delay).
- Word select: lrclk_o = 1 for p in 16..31, 0 for p in 0..15. It transitions one BCLK before each word's MSB.
- Sticky flags:
  - Cleared by clr_flags_i.
  - If a set event and clr_flags_i occur in the same cycle, the set wins.

Optional Feature:
- Macro OPL3_I2S_MONO_EN.
- Defined: L = R = sat16((A + B + C + D) >>> 1), computed with an 18-bit signed sum and arithmetic shift.
- Undefined: stereo mix as above.
- All timing is identical in both builds.

Test Plan:
- Saturation: A = 0x7000, C = 0x7000, B = 0x8000, D = 0xF000, one sample_clk pulse -> FIFO frame L = 0x7FFF, R = 0x8000; level_o = 1.
- Serial format: CLK_DIV = 2, FIFO preloaded with L = 0xA5C3, R = 0x0F01 -> data_o during p = 1..16 gives 1010010111000011, then R MSB-first with R LSB at the next p = 0; lrclk_o high during p = 16..31; BCLK period = 4 clk_i.
- Underrun: enable_i = 1 with no sample_clk -> data_o stays 0, underrun_o = 1 after the first p = 1 load; clr_flags_i pulse -> 0.
- Overflow: enable_i = 1, CLK_DIV = 255, 5 sample_clk pulses before the first pop -> level_o = 4, overflow_o = 1, first serialised frame equals the first captured frame.
- Disable mid-frame: drop enable_i at p = 10 -> next cycle bclk = lrclk = data = 0, level_o = 0. Re-enable -> frame restarts at p = 0 with an underrun frame.
- Mono build (OPL3_I2S_MONO_EN): A = B = C = D = 0x4000 -> L = R = 0x7FFF. A = 0x0100, others 0 -> L = R = 0x0080.

Source files
------------

// File: rtl/opl3_i2s_tx.sv
// OPL3 four-channel capture, saturating stereo mix, frame FIFO and Philips I2S serialiser.
// Optional build macro OPL3_I2S_MONO_EN folds all four channels into a mono L = R mix.
module opl3_i2s_tx #(
    parameter int unsigned CLK_DIV    = 8,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          enable_i,
    input  logic                          clr_flags_i,
    input  logic [15:0]                   channel_a_i,
    input  logic [15:0]                   channel_b_i,
    input  logic [15:0]                   channel_c_i,
    input  logic [15:0]                   channel_d_i,
    input  logic                          sample_clk_i,
    output logic                          i2s_bclk_o,
    output logic                          i2s_lrclk_o,
    output logic                          i2s_data_o,
    output logic [$clog2(FIFO_DEPTH):0]   level_o,
    output logic                          overflow_o,
    output logic                          underrun_o
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);

    typedef enum logic {IDLE, RUN} state_t;

    function automatic logic [15:0] sat16(input logic signed [17:0] v);
        if (v > 18'sd32767)       return 16'h7FFF;
        else if (v < -18'sd32768) return 16'h8000;
        else                      return v[15:0];
    endfunction

    // Capture: 2-flop synchroniser plus edge flop
    logic sync1_q, sync2_q, edge_q;
    logic cap_pulse;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            edge_q  <= 1'b0;
        end else begin
            sync1_q <= sample_clk_i;
            sync2_q <= sync1_q;
            edge_q  <= sync2_q;
        end
    end

    assign cap_pulse = sync2_q & ~edge_q;

    logic [15:0] mix_l, mix_r;
`ifdef OPL3_I2S_MONO_EN
    logic signed [17:0] sum_m;
    logic signed [17:0] half_m;
    assign sum_m  = {{2{channel_a_i[15]}}, channel_a_i} + {{2{channel_b_i[15]}}, channel_b_i}
                  + {{2{channel_c_i[15]}}, channel_c_i} + {{2{channel_d_i[15]}}, channel_d_i};
    assign half_m = sum_m >>> 1;
    assign mix_l  = sat16(half_m);
    assign mix_r  = mix_l;
`else
    logic [16:0] sum_l, sum_r;
    assign sum_l = {channel_a_i[15], channel_a_i} + {channel_c_i[15], channel_c_i};
    assign sum_r = {channel_b_i[15], channel_b_i} + {channel_d_i[15], channel_d_i};
    assign mix_l = sat16({sum_l[16], sum_l});
    assign mix_r = sat16({sum_r[16], sum_r});
`endif

    logic        mix_valid_q;
    logic [31:0] frame_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            mix_valid_q <= 1'b0;
            frame_q     <= '0;
        end else begin
            mix_valid_q <= cap_pulse;
            if (cap_pulse) frame_q <= {mix_l, mix_r};
        end
    end

    // FIFO
    logic [31:0]   mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   count_q;
    logic          empty, full, load, do_push, do_pop;
    logic [31:0]   head_w;

    state_t      state_q;
    logic [7:0]  div_q;
    logic [4:0]  p_q;
    logic        bclk_q;
    logic [31:0] sr_q;
    logic        fall_tick;

    assign empty     = (count_q == '0);
    assign full      = (count_q == (AW+1)'(FIFO_DEPTH));
    assign fall_tick = (state_q == RUN) && enable_i && (div_q == 8'(CLK_DIV - 1)) && bclk_q;
    assign load      = fall_tick && (p_q == 5'd0);
    assign do_pop    = load && !empty;
    assign do_push   = enable_i && mix_valid_q && (!full || do_pop);
    assign head_w    = empty ? '0 : mem[rd_ptr_q];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (!enable_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            if (do_push && !do_pop)      count_q <= count_q + (AW+1)'(1);
            else if (do_pop && !do_push) count_q <= count_q - (AW+1)'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem[wr_ptr_q] <= frame_q;
    end

    assign level_o = count_q;

    // Sticky flags: a set event in the same cycle as a clear wins
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            overflow_o <= 1'b0;
            underrun_o <= 1'b0;
        end else begin
            if (enable_i && mix_valid_q && full && !do_pop) overflow_o <= 1'b1;
            else if (clr_flags_i)                           overflow_o <= 1'b0;
            if (load && empty)    underrun_o <= 1'b1;
            else if (clr_flags_i) underrun_o <= 1'b0;
        end
    end

    // Serialiser: data and lrclk move only on BCLK falling edges
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            div_q       <= '0;
            p_q         <= '0;
            bclk_q      <= 1'b0;
            i2s_lrclk_o <= 1'b0;
            i2s_data_o  <= 1'b0;
            sr_q        <= '0;
        end else begin
            case (state_q)
                RUN: begin
                    if (!enable_i) begin
                        state_q     <= IDLE;
                        div_q       <= '0;
                        p_q         <= '0;
                        bclk_q      <= 1'b0;
                        i2s_lrclk_o <= 1'b0;
                        i2s_data_o  <= 1'b0;
                        sr_q        <= '0;
                    end else if (div_q == 8'(CLK_DIV - 1)) begin
                        div_q  <= '0;
                        bclk_q <= ~bclk_q;
                        if (bclk_q) begin
                            p_q         <= p_q + 5'd1;
                            i2s_lrclk_o <= (p_q + 5'd1) >= 5'd16;
                            if (p_q == 5'd0) begin
                                i2s_data_o <= head_w[31];
                                sr_q       <= {head_w[30:0], 1'b0};
                            end else begin
                                i2s_data_o <= sr_q[31];
                                sr_q       <= {sr_q[30:0], 1'b0};
                            end
                        end
                    end else begin
                        div_q <= div_q + 8'd1;
                    end
                end
                default: begin
                    div_q       <= '0;
                    p_q         <= '0;
                    bclk_q      <= 1'b0;
                    i2s_lrclk_o <= 1'b0;
                    i2s_data_o  <= 1'b0;
                    sr_q        <= '0;
                    if (enable_i) state_q <= RUN;
                end
            endcase
        end
    end

    assign i2s_bclk_o = bclk_q;

endmodule

// File: tb/tb_opl3_i2s_tx.sv
// Directed bench for opl3_i2s_tx: fast instance (CLK_DIV=2) for format/mix, slow one (CLK_DIV=255) for overflow.
module tb_opl3_i2s_tx;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        en0, en1, clr0, clr1, sclk;
    logic [15:0] ch_a, ch_b, ch_c, ch_d;
    logic        bclk0, lr0, dat0, ovf0, und0;
    logic        bclk1, lr1, dat1, ovf1, und1;
    logic [2:0]  lvl0, lvl1;

    opl3_i2s_tx #(.CLK_DIV(2), .FIFO_DEPTH(4)) dut_fast (
        .clk_i(clk), .rst_i(rst), .enable_i(en0), .clr_flags_i(clr0),
        .channel_a_i(ch_a), .channel_b_i(ch_b), .channel_c_i(ch_c), .channel_d_i(ch_d),
        .sample_clk_i(sclk), .i2s_bclk_o(bclk0), .i2s_lrclk_o(lr0), .i2s_data_o(dat0),
        .level_o(lvl0), .overflow_o(ovf0), .underrun_o(und0));

    opl3_i2s_tx #(.CLK_DIV(255), .FIFO_DEPTH(4)) dut_slow (
        .clk_i(clk), .rst_i(rst), .enable_i(en1), .clr_flags_i(clr1),
        .channel_a_i(ch_a), .channel_b_i(ch_b), .channel_c_i(ch_c), .channel_d_i(ch_d),
        .sample_clk_i(sclk), .i2s_bclk_o(bclk1), .i2s_lrclk_o(lr1), .i2s_data_o(dat1),
        .level_o(lvl1), .overflow_o(ovf1), .underrun_o(und1));

    int checks = 0;
    int failures = 0;
    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // I2S receiver for the fast instance: a frame completes at the p = 0 rise (lrclk 1 -> 0)
    logic        bclk0_prev = 1'b0, lr_at_rise = 1'b0;
    logic [31:0] rx_sr = '0, lr_sr = '0, rx_frame = '0, rx_lr = '0;
    int          rx_cnt = 0, rise_idx = 0;
    int unsigned last_rise = 0, bclk_period = 0;

    always @(negedge clk) begin
        bclk0_prev <= bclk0;
        if (bclk0 && !bclk0_prev) begin
            rx_sr       <= {rx_sr[30:0], dat0};
            lr_sr       <= {lr_sr[30:0], lr0};
            bclk_period <= cyc - last_rise;
            last_rise   <= cyc;
            lr_at_rise  <= lr0;
            if (!lr0 && lr_at_rise) begin
                rx_frame <= {rx_sr[30:0], dat0};
                rx_lr    <= {lr_sr[30:0], lr0};
                rx_cnt   <= rx_cnt + 1;
                rise_idx <= 0;
            end else begin
                rise_idx <= rise_idx + 1;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic wait_frame(input string name);
        int start;
        bit ok;
        start = rx_cnt;
        ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (rx_cnt != start) begin
                ok = 1'b1;
                break;
            end
        end
        check({name, "_timeout"}, 32'(ok), 32'd1);
    endtask

    task automatic pulse_sample(input logic [15:0] a, input logic [15:0] b,
                                input logic [15:0] c, input logic [15:0] d);
        ch_a = a; ch_b = b; ch_c = c; ch_d = d;
        sclk = 1'b1;
        repeat (4) @(negedge clk);
        sclk = 1'b0;
    endtask

    typedef struct {
        logic [15:0] a, b, c, d;
        logic [31:0] exp;
    } vec_t;

    vec_t tbl [8];
    localparam logic [31:0] LR_PATTERN = 32'h0001_FFFE;

    initial begin
`ifdef OPL3_I2S_MONO_EN
        tbl[0] = '{16'hA5C3, 16'h0F01, 16'h0000, 16'h0000, 32'hDA62_DA62};
        tbl[1] = '{16'h7000, 16'h8000, 16'h7000, 16'hF000, 32'h2800_2800};
        tbl[2] = '{16'h1234, 16'h0001, 16'h1111, 16'hFFFF, 32'h11A2_11A2};
        tbl[3] = '{16'h8000, 16'h7FFF, 16'h0000, 16'h0001, 32'h0000_0000};
        tbl[4] = '{16'hFFFF, 16'h8001, 16'hFFFF, 16'hFFFF, 32'hBFFF_BFFF};
        tbl[5] = '{16'h4000, 16'hC000, 16'h3FFF, 16'hC000, 32'hFFFF_FFFF};
        tbl[6] = '{16'h4000, 16'h4000, 16'h4000, 16'h4000, 32'h7FFF_7FFF};
        tbl[7] = '{16'h0100, 16'h0000, 16'h0000, 16'h0000, 32'h0080_0080};
`else
        tbl[0] = '{16'hA5C3, 16'h0F01, 16'h0000, 16'h0000, 32'hA5C3_0F01};
        tbl[1] = '{16'h7000, 16'h8000, 16'h7000, 16'hF000, 32'h7FFF_8000};
        tbl[2] = '{16'h1234, 16'h0001, 16'h1111, 16'hFFFF, 32'h2345_0000};
        tbl[3] = '{16'h8000, 16'h7FFF, 16'h0000, 16'h0001, 32'h8000_7FFF};
        tbl[4] = '{16'hFFFF, 16'h8001, 16'hFFFF, 16'hFFFF, 32'hFFFE_8000};
        tbl[5] = '{16'h4000, 16'hC000, 16'h3FFF, 16'hC000, 32'h7FFF_8000};
        tbl[6] = '{16'h4000, 16'h4000, 16'h4000, 16'h4000, 32'h7FFF_7FFF};
        tbl[7] = '{16'h0100, 16'h0000, 16'h0000, 16'h0000, 32'h0100_0000};
`endif
        rst = 1'b1; en0 = 1'b0; en1 = 1'b0; clr0 = 1'b0; clr1 = 1'b0; sclk = 1'b0;
        ch_a = '0; ch_b = '0; ch_c = '0; ch_d = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("reset_fast", {26'd0, bclk0, lr0, dat0, lvl0, ovf0, und0}, 32'd0);
        check("reset_slow", {26'd0, bclk1, lr1, dat1, lvl1, ovf1, und1}, 32'd0);

        // Underrun: running with an empty FIFO plays silence and sets the flag
        en0 = 1'b1;
        wait_frame("und_first");
        check("und_data", rx_frame, 32'd0);
        check("und_flag", 32'(und0), 32'd1);
        check("und_lrclk", rx_lr, LR_PATTERN);
        check("bclk_period", bclk_period, 32'd4);
        wait_frame("und_second");
        repeat (4) @(negedge clk);
        clr0 = 1'b1;
        @(negedge clk);
        clr0 = 1'b0;
        check("und_clear", 32'(und0), 32'd0);
        check("ovf_idle", 32'(ovf0), 32'd0);

        // Mix/saturation vectors, each pushed and read back through the serial stream
        for (int unsigned v = 0; v < 8; v++) begin
            bit gone;
            wait_frame($sformatf("vec%0d_sync", v));
            pulse_sample(tbl[v].a, tbl[v].b, tbl[v].c, tbl[v].d);
            repeat (6) @(negedge clk);
            check($sformatf("vec%0d_level", v), 32'(lvl0), 32'd1);
            gone = 1'b0;
            for (int i = 0; i < 200; i++) begin
                @(negedge clk);
                if (lvl0 == 3'd0) begin
                    gone = 1'b1;
                    break;
                end
            end
            check($sformatf("vec%0d_pop", v), 32'(gone), 32'd1);
            wait_frame($sformatf("vec%0d_rx", v));
            check($sformatf("vec%0d_frame", v), rx_frame, tbl[v].exp);
            check($sformatf("vec%0d_lrclk", v), rx_lr, LR_PATTERN);
        end

        // Disable mid-frame at p = 10, then re-enable
        begin
            bit hit;
            wait_frame("dis_sync0");
            pulse_sample(16'h7FFF, 16'h7FFF, 16'h0000, 16'h0000);
            wait_frame("dis_sync1");
            pulse_sample(16'h7FFF, 16'h7FFF, 16'h0000, 16'h0000);
            hit = 1'b0;
            for (int i = 0; i < 100; i++) begin
                if (rise_idx == 10) begin
                    hit = 1'b1;
                    break;
                end
                @(negedge clk);
            end
            check("dis_reach_p10", 32'(hit), 32'd1);
            check("dis_p10_data", 32'(dat0), 32'd1);
            check("dis_p10_level", 32'(lvl0), 32'd1);
            en0 = 1'b0;
            @(negedge clk);
            check("dis_outputs", {29'd0, bclk0, lr0, dat0}, 32'd0);
            check("dis_level", 32'(lvl0), 32'd0);
            clr0 = 1'b1;
            @(negedge clk);
            clr0 = 1'b0;
            check("dis_flag_clr", 32'(und0), 32'd0);
            en0 = 1'b1;
            wait_frame("reen_rx");
            check("reen_frame", rx_frame, 32'd0);
            check("reen_underrun", 32'(und0), 32'd1);
            check("reen_lrclk", rx_lr, LR_PATTERN);
            en0 = 1'b0;
        end

        // Overflow on the slow instance: five frames arrive before the first pop
        begin
            int rises;
            logic [31:0] w;
            logic prev;
            logic [31:0] exp_first;
`ifdef OPL3_I2S_MONO_EN
            exp_first = 32'h0088_0088;
`else
            exp_first = 32'h0100_0010;
`endif
            @(negedge clk);
            en1 = 1'b1;
            for (int unsigned k = 1; k <= 5; k++) begin
                pulse_sample(16'(16'h0100 * k), 16'(16'h0010 * k), 16'h0000, 16'h0000);
                repeat (4) @(negedge clk);
            end
            check("ovf_level", 32'(lvl1), 32'd4);
            check("ovf_flag", 32'(ovf1), 32'd1);
            check("ovf_no_underrun", 32'(und1), 32'd0);
            rises = 0;
            w = '0;
            prev = bclk1;
            for (int i = 0; i < 40000 && rises < 33; i++) begin
                @(negedge clk);
                if (bclk1 && !prev) begin
                    rises++;
                    if (rises >= 2) w = {w[30:0], dat1};
                end
                prev = bclk1;
            end
            check("ovf_rx_timeout", 32'(rises), 32'd33);
            check("ovf_first_frame", w, exp_first);
            check("ovf_level_after_pop", 32'(lvl1), 32'd3);
            clr1 = 1'b1;
            @(negedge clk);
            clr1 = 1'b0;
            check("ovf_clear", 32'(ovf1), 32'd0);
            en1 = 1'b0;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
